// File: rtl/arbitrate.sv
// N-to-1 arbiter feeding a one-entry registered output slot {source index, payload}.
// Define ARBITRATE_ROUND_ROBIN_EN for round-robin arbitration; otherwise fixed priority (lowest index wins).
module arbitrate #(
  parameter int W = 8,
  parameter int N = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N-1:0]           s_stb,
  input  logic [N*W-1:0]         s_dat,
  output logic [N-1:0]           s_rdy,
  input  logic                   m_rdy,
  output logic                   m_stb,
  output logic [$clog2(N)+W-1:0] m_dat
);

  localparam int IW = $clog2(N);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [IW+W-1:0] dat_q, dat_d;
  logic [IW-1:0]   grant;
  logic            found;
  logic            any_req;
  logic            open;
  logic            s_xfer;
  logic [W-1:0]    lane [N];
  logic [W-1:0]    sel_dat;

  always_comb begin
    for (int unsigned k = 0; k < N; k++) begin
      lane[k] = s_dat[k*W +: W];
    end
  end

`ifdef ARBITRATE_ROUND_ROBIN_EN
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] idx;

  // Search starts one past the last winner, wrapping modulo N (N need not be a power of two).
  always_comb begin
    grant = ptr_q;
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 1; i <= N; i++) begin
      idx = IW'((int'(ptr_q) + int'(i)) % N);
      if (!found && s_stb[idx]) begin
        grant = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (s_xfer) begin
      ptr_d = grant;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= IW'(N - 1);
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!found && s_stb[IW'(i)]) begin
        grant = IW'(i);
        found = 1'b1;
      end
    end
  end
`endif

  always_comb begin
    any_req = |s_stb;
    open    = (state_q == EMPTY) || m_rdy;
    s_rdy   = '0;
    // Gated by rst so no handshake can be observed while reset is held.
    if (!rst && any_req && open) begin
      s_rdy[grant] = 1'b1;
    end
    s_xfer  = |(s_stb & s_rdy);
    sel_dat = lane[grant];
  end

  always_comb begin
    state_d = state_q;
    dat_d   = dat_q;
    case (state_q)
      EMPTY: begin
        if (s_xfer) begin
          state_d = FULL;
          dat_d   = {grant, sel_dat};
        end
      end
      FULL: begin
        if (s_xfer) begin
          dat_d = {grant, sel_dat};
        end else if (m_rdy) begin
          state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      dat_q   <= dat_d;
    end
  end

  assign m_stb = (state_q == FULL);
  assign m_dat = dat_q;

endmodule

// File: tb/tb_arbitrate.sv
// Self-checking bench for arbitrate (W=8, N=4): vector table, directed corner sequences,
// and randomized traffic against a behavioural model.
module tb_arbitrate;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  s_stb;
  logic [31:0] s_dat;
  logic [3:0]  s_rdy;
  logic        m_rdy;
  logic        m_stb;
  logic [9:0]  m_dat;

  int n_chk  = 0;
  int n_fail = 0;

  arbitrate #(.W(8), .N(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .s_stb(s_stb),
    .s_dat(s_dat),
    .s_rdy(s_rdy),
    .m_rdy(m_rdy),
    .m_stb(m_stb),
    .m_dat(m_dat)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [3:0]  stb;
    logic [31:0] dat;
    logic        mrdy;
    logic [3:0]  exp_rdy;
    logic        exp_stb;
    logic [9:0]  exp_dat;
  } vec_t;

  vec_t tbl [7];

  // Behavioural model state
  bit       mdl_full;
  bit [9:0] mdl_dat;
  int       mdl_ptr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle: inputs applied, s_rdy sampled before the edge, returns #1 after the edge.
  task automatic apply(input logic [3:0] stb, input logic [31:0] dat, input logic mrdy,
                       output logic [3:0] rdy_seen);
    s_stb = stb;
    s_dat = dat;
    m_rdy = mrdy;
    #2;
    rdy_seen = s_rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    s_stb = 4'b1111;
    s_dat = 32'hDEADBEEF;
    m_rdy = 1'b1;
    #2;
    chk("reset_s_rdy", 32'(s_rdy), 32'h0);
    chk("reset_m_stb", 32'(m_stb), 32'h0);
    chk("reset_m_dat", 32'(m_dat), 32'h0);
    @(posedge clk);
    #1;
    rst      = 1'b0;
    s_stb    = '0;
    mdl_full = 1'b0;
    mdl_dat  = '0;
    mdl_ptr  = 3;
  endtask

  function automatic int model_grant(input logic [3:0] stb, input int p);
`ifdef ARBITRATE_ROUND_ROBIN_EN
    for (int off = 1; off <= 4; off++) begin
      int k = (p + off) % 4;
      if (((stb >> k) & 4'b0001) != 4'b0000) return k;
    end
`else
    for (int k = 0; k < 4; k++) begin
      if (((stb >> k) & 4'b0001) != 4'b0000) return k;
    end
`endif
    return -1;
  endfunction

  initial begin
    logic [3:0] rdy;
    rst   = 1'b1;
    s_stb = '0;
    s_dat = '0;
    m_rdy = 1'b0;

    tbl[0] = '{4'b0100, 32'h00A50000, 1'b1, 4'b0100, 1'b1, 10'h2A5};
    tbl[1] = '{4'b0000, 32'h00000000, 1'b1, 4'b0000, 1'b0, 10'h000};
    tbl[2] = '{4'b0001, 32'h0000003C, 1'b0, 4'b0001, 1'b1, 10'h03C};
    tbl[3] = '{4'b1000, 32'h77000000, 1'b0, 4'b0000, 1'b1, 10'h03C};
    tbl[4] = '{4'b1000, 32'h77000000, 1'b1, 4'b1000, 1'b1, 10'h377};
    tbl[5] = '{4'b0000, 32'h00000000, 1'b0, 4'b0000, 1'b1, 10'h377};
    tbl[6] = '{4'b0000, 32'h00000000, 1'b1, 4'b0000, 1'b0, 10'h000};

    #3;
    do_reset();

    for (int i = 0; i < 7; i++) begin
      apply(tbl[i].stb, tbl[i].dat, tbl[i].mrdy, rdy);
      chk($sformatf("tbl%0d_s_rdy", i), 32'(rdy), 32'(tbl[i].exp_rdy));
      chk($sformatf("tbl%0d_m_stb", i), 32'(m_stb), 32'(tbl[i].exp_stb));
      if (tbl[i].exp_stb) chk($sformatf("tbl%0d_m_dat", i), 32'(m_dat), 32'(tbl[i].exp_dat));
    end

    // Asynchronous reset in mid-cycle while FULL
    apply(4'b0001, 32'h00000011, 1'b0, rdy);
    chk("prerst_m_stb", 32'(m_stb), 32'h1);
    @(negedge clk);
    s_stb = 4'b1111;
    rst   = 1'b1;
    #1;
    chk("async_rst_m_stb", 32'(m_stb), 32'h0);
    chk("async_rst_m_dat", 32'(m_dat), 32'h0);
    chk("async_rst_s_rdy", 32'(s_rdy), 32'h0);
    @(posedge clk);
    #1;
    chk("held_rst_m_stb", 32'(m_stb), 32'h0);
    chk("held_rst_s_rdy", 32'(s_rdy), 32'h0);
    rst = 1'b0;

    // All slaves requesting with a free-flowing master
    do_reset();
    for (int i = 0; i < 5; i++) begin
`ifdef ARBITRATE_ROUND_ROBIN_EN
      int idx = i % 4;
`else
      int idx = 0;
`endif
      apply(4'b1111, 32'h13121110, 1'b1, rdy);
      chk($sformatf("all_req%0d_s_rdy", i), 32'(rdy), 32'(1) << idx);
      chk($sformatf("all_req%0d_m_stb", i), 32'(m_stb), 32'h1);
      chk($sformatf("all_req%0d_m_dat", i), 32'(m_dat), (32'(idx) << 8) | (32'h10 + 32'(idx)));
    end

    // Backpressure: hold 0x1C3 for 5 cycles, then drain and refill on the same edge
    do_reset();
    apply(4'b0010, 32'h0000C300, 1'b0, rdy);
    chk("bp_load_m_dat", 32'(m_dat), 32'h1C3);
    for (int i = 0; i < 5; i++) begin
      apply(4'b1010, 32'hE1005A00, 1'b0, rdy);
      chk($sformatf("bp%0d_s_rdy", i), 32'(rdy), 32'h0);
      chk($sformatf("bp%0d_m_dat", i), 32'(m_dat), 32'h1C3);
      chk($sformatf("bp%0d_m_stb", i), 32'(m_stb), 32'h1);
    end
    apply(4'b1010, 32'hE1005A00, 1'b1, rdy);
`ifdef ARBITRATE_ROUND_ROBIN_EN
    chk("bp_release_s_rdy", 32'(rdy), 32'b1000);
    chk("bp_release_m_dat", 32'(m_dat), 32'h3E1);
`else
    chk("bp_release_s_rdy", 32'(rdy), 32'b0010);
    chk("bp_release_m_dat", 32'(m_dat), 32'h15A);
`endif
    chk("bp_release_m_stb", 32'(m_stb), 32'h1);

    // Withdrawn request while stalled leaves slot and pointer untouched
    do_reset();
    apply(4'b0001, 32'h00000042, 1'b0, rdy);
    chk("wd_load_m_dat", 32'(m_dat), 32'h042);
    apply(4'b0010, 32'h00009900, 1'b0, rdy);
    chk("wd_req_s_rdy", 32'(rdy), 32'h0);
    chk("wd_req_m_stb", 32'(m_stb), 32'h1);
    chk("wd_req_m_dat", 32'(m_dat), 32'h042);
    apply(4'b0000, 32'h00009900, 1'b0, rdy);
    chk("wd_drop_m_stb", 32'(m_stb), 32'h1);
    chk("wd_drop_m_dat", 32'(m_dat), 32'h042);
    apply(4'b1111, 32'h44332211, 1'b1, rdy);
`ifdef ARBITRATE_ROUND_ROBIN_EN
    chk("wd_after_s_rdy", 32'(rdy), 32'b0010);
    chk("wd_after_m_dat", 32'(m_dat), 32'h122);
`else
    chk("wd_after_s_rdy", 32'(rdy), 32'b0001);
    chk("wd_after_m_dat", 32'(m_dat), 32'h011);
`endif

    // Randomized traffic against the behavioural model
    do_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      logic [3:0]  stb;
      logic [31:0] dat;
      logic        mrdy;
      logic [3:0]  exp_rdy;
      bit          open;
      int          g;
      stb  = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) stb = '0;
      dat  = $urandom;
      mrdy = ($urandom_range(0, 3) != 0);
      open = !mdl_full || mrdy;
      g    = model_grant(stb, mdl_ptr);
      exp_rdy = (g >= 0 && open) ? 4'(1 << g) : 4'b0000;
      apply(stb, dat, mrdy, rdy);
      if (g >= 0 && open) begin
        mdl_full = 1'b1;
        mdl_dat  = {2'(g), 8'(dat >> (8 * g))};
        mdl_ptr  = g;
      end else if (mdl_full && mrdy) begin
        mdl_full = 1'b0;
      end
      chk("rand_s_rdy", 32'(rdy), 32'(exp_rdy));
      chk("rand_m_stb", 32'(m_stb), 32'(mdl_full));
      if (mdl_full) chk("rand_m_dat", 32'(m_dat), 32'(mdl_dat));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
